// File: rtl/mk14_disp_pkg.sv
// Shared types and sizes for the MK14 multiplexed LED display driver.
package mk14_disp_pkg;

   localparam int unsigned DIGITS = 8;
   localparam int unsigned SEG_W  = 8;
   localparam int unsigned IDX_W  = $clog2(DIGITS);

   typedef logic [SEG_W-1:0]  seg_t;
   typedef logic [DIGITS-1:0] dig_t;
   typedef logic [IDX_W-1:0]  idx_t;
   typedef seg_t [DIGITS-1:0] image_t;

   typedef enum logic {ST_BLANK, ST_SHOW} disp_state_t;

   // Active-high one-hot select for the given digit position.
   function automatic dig_t digit_onehot(input idx_t idx);
      return dig_t'(1) << idx;
   endfunction

endpackage

// File: rtl/mk14_scan_timer.sv
// Slot counter for the display scan: wraps every SLOT_CYCLES clocks, strobes blank-end and wrap.
// With MK14_DISP_DIM_EN defined the raw count is also exported for the dimming window.
module mk14_scan_timer
   import mk14_disp_pkg::*;
#(
   parameter int unsigned SLOT_CYCLES  = 10,
   parameter int unsigned BLANK_CYCLES = 2,
   parameter int unsigned CNT_W        = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
`ifdef MK14_DISP_DIM_EN
   output logic [CNT_W-1:0] cnt_o,
`endif
   output logic             blank_end_c_o,
   output logic             wrap_c_o
);

   if (BLANK_CYCLES < 1 || BLANK_CYCLES >= SLOT_CYCLES) begin : g_bad_blank
      $error("mk14_scan_timer: BLANK_CYCLES (%0d) must be in 1..SLOT_CYCLES-1 (%0d)",
             BLANK_CYCLES, SLOT_CYCLES);
   end

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign wrap_c_o      = en_i && (cnt_q == CNT_W'(SLOT_CYCLES - 1));
   assign blank_end_c_o = en_i && (cnt_q == CNT_W'(BLANK_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (en_i) begin
         cnt_d = wrap_c_o ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

`ifdef MK14_DISP_DIM_EN
   assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/mk14_display_mux.sv
// Time-multiplexes the 8-digit segment image onto a shared segment bus with per-digit enables.
// Optional MK14_DISP_DIM_EN adds a 4-bit brightness input that shortens each digit's lit window.
module mk14_display_mux
   import mk14_disp_pkg::*;
#(
   parameter int unsigned CLOCK_FREQ_MHZ = 12,
   parameter int unsigned SCAN_HZ        = 1000,
   parameter int unsigned BLANK_CYCLES   = 16,
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [DIGITS*SEG_W-1:0] display,
`ifdef MK14_DISP_DIM_EN
   input  logic [3:0]              brightness,
`endif
   output seg_t                    seg,
   output dig_t                    dig,
   output logic                    frame_start
);

   localparam int unsigned SLOT_CYCLES = CLOCK_FREQ_MHZ * 1_000_000 / SCAN_HZ;
   localparam int unsigned CNT_W       = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
   localparam seg_t        SEG_OFF     = SEG_ACTIVE_LOW ? '1 : '0;
   localparam dig_t        DIG_OFF     = DIG_ACTIVE_LOW ? '1 : '0;

   disp_state_t state_q, state_d;
   idx_t        idx_q, idx_d;
   logic        first_q;
   image_t      shadow_q;
   seg_t        seg_q, seg_d;
   dig_t        dig_q, dig_d;
   logic        fs_q, fs_d;
   logic        load_c;
   logic        lit_c;
   logic        blank_end_c, wrap_c;

`ifdef MK14_DISP_DIM_EN
   logic [CNT_W-1:0] cnt;
   logic [3:0]       bright_q;
   logic [31:0]      offs_c, on_cycles_c;
`endif

   // Counter is held for the post-reset sampling cycle so every frame is exactly 8 slots.
   mk14_scan_timer #(
      .SLOT_CYCLES  (SLOT_CYCLES),
      .BLANK_CYCLES (BLANK_CYCLES),
      .CNT_W        (CNT_W)
   ) u_timer (
      .clk           (clk),
      .rst_n         (rst_n),
      .en_i          (!first_q),
`ifdef MK14_DISP_DIM_EN
      .cnt_o         (cnt),
`endif
      .blank_end_c_o (blank_end_c),
      .wrap_c_o      (wrap_c)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_BLANK;
         idx_q    <= '0;
         first_q  <= 1'b1;
         shadow_q <= '0;
         seg_q    <= SEG_OFF;
         dig_q    <= DIG_OFF;
         fs_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         first_q  <= 1'b0;
         seg_q    <= seg_d;
         dig_q    <= dig_d;
         fs_q     <= fs_d;
         if (load_c) begin
            shadow_q <= image_t'(display);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
         ST_BLANK: begin
            if (blank_end_c) begin
               state_d = ST_SHOW;
            end
         end
         ST_SHOW: begin
            if (wrap_c) begin
               state_d = ST_BLANK;
               idx_d   = idx_q + idx_t'(1);
            end
         end
         default: state_d = ST_BLANK;
      endcase
   end

   // New frame: image is latched as the scan re-enters digit 0's blank.
   assign load_c = first_q || (state_q == ST_SHOW && wrap_c && idx_q == idx_t'(DIGITS - 1));

`ifdef MK14_DISP_DIM_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bright_q <= 4'hF;
      end else if (load_c) begin
         bright_q <= brightness;
      end
   end

   // Offset is taken for the cycle being registered, one ahead of the counter.
   always_comb begin
      offs_c      = 32'(cnt) + 32'd1 - 32'(BLANK_CYCLES);
      on_cycles_c = (32'(SLOT_CYCLES - BLANK_CYCLES) * (32'(bright_q) + 32'd1)) >> 4;
      lit_c       = offs_c < on_cycles_c;
   end
`else
   assign lit_c = 1'b1;
`endif

   // Outputs are computed from the next state so they line up with state_q.
   always_comb begin
      seg_d = SEG_OFF;
      dig_d = DIG_OFF;
      fs_d  = load_c;
      if (state_d == ST_SHOW && lit_c) begin
         seg_d = SEG_ACTIVE_LOW ? ~shadow_q[idx_d] : shadow_q[idx_d];
         dig_d = DIG_ACTIVE_LOW ? ~digit_onehot(idx_d) : digit_onehot(idx_d);
      end
   end

   assign seg         = seg_q;
   assign dig         = dig_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_mk14_display_mux.sv
// Directed bench for mk14_display_mux (SLOT_CYCLES=10, BLANK_CYCLES=2, active-low outputs).
// Exercises dimming when MK14_DISP_DIM_EN is defined.
module tb_mk14_display_mux;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] display = '0;
   logic [3:0]  brightness = 4'hF;
   logic [7:0]  seg, dig;
   logic        frame_start;

   int n_vec = 0;
   int n_err = 0;

   logic [63:0] img_a = 64'h8040201008040201;
   logic [63:0] img_b = 64'hF0E1D2C3B4A59687;
   logic [63:0] img_c = 64'h7F065B4F666D7D07;

   logic [7:0] prev_seg = 8'hFF;
   logic [7:0] prev_dig = 8'hFF;

   mk14_display_mux #(
      .CLOCK_FREQ_MHZ (1),
      .SCAN_HZ        (100000),
      .BLANK_CYCLES   (2),
      .SEG_ACTIVE_LOW (1'b1),
      .DIG_ACTIVE_LOW (1'b1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .display     (display),
`ifdef MK14_DISP_DIM_EN
      .brightness  (brightness),
`endif
      .seg         (seg),
      .dig         (dig),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One 10-clock slot: 2 blank clocks, then `lit` lit clocks, rest of SHOW dark.
   task automatic run_slot(input int d, input logic [7:0] b, input bit first, input int lit,
                           input bit do_chg, input logic [63:0] new_img);
      logic [7:0] onehot;
      onehot = 8'h01 << d;
      for (int c = 0; c < 10; c++) begin
         if (!(first && c == 0)) tick();
         if (c >= 2 && c < 2 + lit) begin
            chk($sformatf("dig d%0d c%0d", d, c), dig, ~onehot);
            chk($sformatf("seg d%0d c%0d", d, c), seg, ~b);
         end else begin
            chk($sformatf("dig_off d%0d c%0d", d, c), dig, 8'hFF);
            chk($sformatf("seg_off d%0d c%0d", d, c), seg, 8'hFF);
         end
         chk($sformatf("frame_start d%0d c%0d", d, c), {7'd0, frame_start},
             {7'd0, (d == 0 && c == 0)});
         if (do_chg && c == 4) display = new_img;
      end
   endtask

   task automatic run_frame(input logic [63:0] img, input bit first, input int lit,
                            input int ndig, input int chg_d, input logic [63:0] new_img);
      for (int d = 0; d < ndig; d++) begin
         run_slot(d, img[8*d +: 8], first && d == 0, lit, d == chg_d, new_img);
      end
   endtask

   // Anti-ghosting invariants, sampled mid-cycle.
   always @(negedge clk) begin
      n_vec++;
      assert ($countones(~dig) <= 1) else begin
         n_err++;
         $error("FAIL onehot: observed dig %h expected at most one active", dig);
      end
      if (prev_dig != 8'hFF && dig != 8'hFF) begin
         n_vec++;
         assert (seg === prev_seg) else begin
            n_err++;
            $error("FAIL seg_stable: observed seg %h expected %h while lit", seg, prev_seg);
         end
      end
      prev_seg = seg;
      prev_dig = dig;
   end

   initial begin
      // Reset held three clocks
      rst_n = 1'b0;
      tick(); tick(); tick();
      chk("rst_seg", seg, 8'hFF);
      chk("rst_dig", dig, 8'hFF);
      chk("rst_fs", {7'd0, frame_start}, 8'h00);

      // Walking-bit image, two full frames
      display = img_a;
      rst_n   = 1'b1;
      tick();
      run_frame(img_a, 1'b1, 8, 8, -1, '0);
      run_frame(img_a, 1'b0, 8, 8, -1, '0);

      // Display changed while digit 3 is shown: old image holds until next frame
      run_frame(img_a, 1'b0, 8, 8, 3, img_b);
      run_frame(img_b, 1'b0, 8, 8, -1, '0);

      // Reset pulse inside digit 5's SHOW window
      run_frame(img_b, 1'b0, 8, 5, -1, '0);
      tick(); tick(); tick();
      chk("pre_rst_dig5", dig, 8'hDF);
      chk("pre_rst_seg5", seg, ~img_b[47:40]);
      rst_n   = 1'b0;
      display = img_c;
      tick();
      chk("mid_rst_seg", seg, 8'hFF);
      chk("mid_rst_dig", dig, 8'hFF);
      chk("mid_rst_fs", {7'd0, frame_start}, 8'h00);
      rst_n = 1'b1;
      tick();
      run_frame(img_c, 1'b1, 8, 8, -1, '0);

`ifdef MK14_DISP_DIM_EN
      // Brightness takes effect at the next frame boundary
      brightness = 4'd3;
      run_frame(img_c, 1'b0, 2, 8, -1, '0);
      brightness = 4'd15;
      run_frame(img_c, 1'b0, 8, 8, -1, '0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
